// File: rtl/jtcop_ba0_arb.sv
// Bank-0 SDRAM scheduler for Dec0: main ROM, work RAM and sound ROM share one
// SDRAM bank, each requester sitting behind a one-word cache.
module jtcop_ba0_arb #(
  parameter int          AW          = 18,
  parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
  parameter logic [21:0] RAM_OFFSET  = 22'h30_0000,
  parameter logic [21:0] SND_OFFSET  = 22'h20_0000
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic [AW-1:0] main_addr,
  output logic          main_ok,
  output logic [15:0]   main_data,
  input  logic          ram_cs,
  input  logic [AW-1:0] ram_addr,
  input  logic          ram_rnw,
  input  logic [1:0]    ram_dsn,
  input  logic [15:0]   ram_din,
  output logic          ram_ok,
  output logic [15:0]   ram_data,
  input  logic          snd_cs,
  input  logic [AW:0]   snd_addr,
  output logic          snd_ok,
  output logic [7:0]    snd_data,
  output logic [21:0]   ba_addr,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [15:0]   ba_din,
  output logic [1:0]    ba_din_m,
  input  logic          ba_ack,
  input  logic          ba_rdy,
  input  logic [15:0]   data_read
);
  // SDRAM handshake: a request (ba_rd/ba_wr) is held until ba_ack is sampled
  // high; ba_rdy then ends the transfer and is only honoured in WAIT.
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic [2:0][AW-1:0] c_addr;
  logic [2:0][15:0]   c_data;
  logic [2:0]         valid;
  logic [1:0]         last_grant, gnt, gnt_r, c1, c2, c3;
  logic               gnt_vld, start, finish, is_wr;
  logic [AW-1:0]      gnt_addr, sel_addr, wdone_addr;
  logic [21:0]        sel_base;
  logic               wdone, wdone_eff, snd_sel;
  logic [AW-1:0]      snd_waddr;
  logic               hit_main, hit_ram, hit_snd;
  logic [3:0]         pend;

  assign snd_waddr = snd_addr[AW:1];
  assign hit_main  = main_cs & valid[0] & (main_addr == c_addr[0]);
  assign hit_ram   = ram_cs & ram_rnw & valid[1] & (ram_addr == c_addr[1]);
  assign hit_snd   = snd_cs & valid[2] & (snd_waddr == c_addr[2]);
  // A finished write only counts while the CPU keeps the same access up
  assign wdone_eff = wdone & ram_cs & (ram_addr == wdone_addr);

  assign pend[0] = main_cs & ~hit_main;
  assign pend[1] = ram_cs & (ram_rnw ? ~hit_ram : ~wdone_eff);
  assign pend[2] = snd_cs & ~hit_snd;
  assign pend[3] = 1'b0;

  assign main_data = c_data[0];
  assign ram_data  = c_data[1];
  assign snd_data  = snd_sel ? c_data[2][15:8] : c_data[2][7:0];

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  always_comb begin
    c1      = rr_next(last_grant);
    c2      = rr_next(c1);
    c3      = rr_next(c2);
    gnt     = last_grant;
    gnt_vld = 1'b1;
    if (pend[c1])      gnt = c1;
    else if (pend[c2]) gnt = c2;
    else if (pend[c3]) gnt = c3;
    else               gnt_vld = 1'b0;
  end

  always_comb begin
    sel_addr = main_addr;
    sel_base = MAIN_OFFSET;
    case (gnt)
      2'd1: begin sel_addr = ram_addr;  sel_base = RAM_OFFSET; end
      2'd2: begin sel_addr = snd_waddr; sel_base = SND_OFFSET; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (gnt_vld) begin state_nxt = REQ; start = 1'b1; end
      REQ:  if (ba_ack) state_nxt = WAIT;
      WAIT: if (ba_rdy) begin state_nxt = IDLE; finish = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ok    <= 1'b0;
      ram_ok     <= 1'b0;
      snd_ok     <= 1'b0;
      snd_sel    <= 1'b0;
      ba_addr    <= '0;
      ba_rd      <= 1'b0;
      ba_wr      <= 1'b0;
      ba_din     <= '0;
      ba_din_m   <= '0;
      c_addr     <= '0;
      c_data     <= '0;
      valid      <= '0;
      wdone      <= 1'b0;
      wdone_addr <= '0;
      last_grant <= 2'd2;
      gnt_r      <= 2'd0;
      gnt_addr   <= '0;
      is_wr      <= 1'b0;
    end else begin
      main_ok <= hit_main;
      snd_ok  <= hit_snd;
      ram_ok  <= hit_ram | (~ram_rnw & wdone_eff);
      snd_sel <= snd_addr[0];
      if (!wdone_eff) wdone <= 1'b0;
      if (start) begin
        last_grant <= gnt;
        gnt_r      <= gnt;
        gnt_addr   <= sel_addr;
        ba_addr    <= sel_base + 22'(sel_addr);
        is_wr      <= (gnt == 2'd1) & ~ram_rnw;
        ba_rd      <= ~((gnt == 2'd1) & ~ram_rnw);
        ba_wr      <= (gnt == 2'd1) & ~ram_rnw;
        if ((gnt == 2'd1) && !ram_rnw) begin
          ba_din   <= ram_din;
          ba_din_m <= ram_dsn;
        end
      end
      if (state == REQ && ba_ack) begin
        ba_rd <= 1'b0;
        ba_wr <= 1'b0;
      end
      if (finish) begin
        if (is_wr) begin
          wdone      <= 1'b1;
          wdone_addr <= gnt_addr;
          // Keep the read cache coherent with the bytes just written
          if (valid[1] && c_addr[1] == gnt_addr)
            c_data[1] <= {ba_din_m[1] ? c_data[1][15:8] : ba_din[15:8],
                          ba_din_m[0] ? c_data[1][7:0]  : ba_din[7:0]};
        end else begin
          c_data[gnt_r] <= data_read;
          c_addr[gnt_r] <= gnt_addr;
          valid[gnt_r]  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtcop_ba0_arb.sv
// Bench for jtcop_ba0_arb: SDRAM responder, per-cycle cache model compare and
// directed scenarios with literal expectations.
module tb_jtcop_ba0_arb;
  localparam int AW = 18;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          main_cs, ram_cs, ram_rnw, snd_cs;
  logic [AW-1:0] main_addr, ram_addr;
  logic [AW:0]   snd_addr;
  logic [1:0]    ram_dsn;
  logic [15:0]   ram_din, data_read;
  logic          ba_ack, ba_rdy;
  logic          main_ok, ram_ok, snd_ok, ba_rd, ba_wr;
  logic [15:0]   main_data, ram_data, ba_din;
  logic [7:0]    snd_data;
  logic [21:0]   ba_addr;
  logic [1:0]    ba_din_m;

  always #5 clk = ~clk;

  jtcop_ba0_arb dut (
    .clk(clk), .rst_n(rst_n),
    .main_cs(main_cs), .main_addr(main_addr), .main_ok(main_ok), .main_data(main_data),
    .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_rnw(ram_rnw), .ram_dsn(ram_dsn),
    .ram_din(ram_din), .ram_ok(ram_ok), .ram_data(ram_data),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_ok(snd_ok), .snd_data(snd_data),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SDRAM content: explicit presets, otherwise a fixed address pattern
  logic [15:0] mem [logic [21:0]];
  function automatic logic [15:0] mem_rd(input logic [21:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'hC3A5;
  endfunction

  // SDRAM controller side: ack after ack_dly, rdy rdy_dly cycles after ack
  int ack_dly = 0, rdy_dly = 1, phase = 0, cnt = 0, req_cnt = 0;
  logic [21:0] x_addr = '0;
  logic        x_rd = 1'b0;
  logic [21:0] glog [$];

  initial begin
    ba_ack = 1'b0; ba_rdy = 1'b0; data_read = '0;
    forever begin
      @(negedge clk);
      ba_ack = 1'b0;
      ba_rdy = 1'b0;
      if (!rst_n) phase = 0;
      else begin
        if (phase == 0 && (ba_rd || ba_wr)) begin
          x_addr = ba_addr;
          x_rd   = ba_rd;
          req_cnt++;
          glog.push_back(ba_addr);
          if (ba_wr) begin
            check("wr_din", ba_din, ram_din);
            check("wr_mask", ba_din_m, ram_dsn);
          end
          cnt   = ack_dly;
          phase = 1;
        end else if (phase != 0) begin
          check("addr_stable", ba_addr, x_addr);
          check("req_level", ba_rd | ba_wr, (phase == 1) ? 1 : 0);
        end
        if (phase == 1) begin
          if (cnt == 0) begin ba_ack = 1'b1; phase = 2; cnt = rdy_dly; end
          else cnt--;
        end else if (phase == 2) begin
          cnt--;
          if (cnt <= 0) begin
            ba_rdy = 1'b1;
            if (x_rd) data_read = mem_rd(x_addr);
            else mem[x_addr] = {ram_dsn[1] ? mem_rd(x_addr) >> 8 : {8'h0, ram_din[15:8]},
                                8'h00} | {8'h00, ram_dsn[0] ? mem_rd(x_addr) & 16'h00FF : {8'h0, ram_din[7:0]}} ;
            phase = 0;
          end
        end
      end
    end
  end

  // Cache model: which word each requester may see, and when ok is due
  logic          mv [3];
  logic [AW-1:0] ma [3];
  logic [15:0]   md [3];
  logic          mwd = 1'b0;
  logic [AW-1:0] mwa = '0;
  logic          e_main = 1'b0, e_ram = 1'b0, e_snd = 1'b0;
  logic [15:0]   e_main_d = '0, e_ram_d = '0;
  logic [7:0]    e_snd_d = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; ma[i] = '0; md[i] = '0; end
      mwd = 1'b0; e_main = 1'b0; e_ram = 1'b0; e_snd = 1'b0;
    end else begin
      e_main   = main_cs && mv[0] && ma[0] == main_addr;
      e_main_d = md[0];
      e_ram    = ram_cs && ((ram_rnw && mv[1] && ma[1] == ram_addr) ||
                            (!ram_rnw && mwd && mwa == ram_addr));
      e_ram_d  = md[1];
      e_snd    = snd_cs && mv[2] && ma[2] == snd_addr[AW:1];
      e_snd_d  = snd_addr[0] ? md[2][15:8] : md[2][7:0];
      if (!ram_cs || ram_addr != mwa) mwd = 1'b0;
      if (ba_rdy) begin
        int s;
        logic [21:0] a;
        if (x_addr >= 22'h30_0000)      begin s = 1; a = x_addr - 22'h30_0000; end
        else if (x_addr >= 22'h20_0000) begin s = 2; a = x_addr - 22'h20_0000; end
        else                            begin s = 0; a = x_addr; end
        if (x_rd) begin
          mv[s] = 1'b1; ma[s] = a[AW-1:0]; md[s] = data_read;
        end else begin
          mwd = 1'b1; mwa = a[AW-1:0];
          if (mv[1] && ma[1] == a[AW-1:0]) begin
            if (!ram_dsn[1]) md[1][15:8] = ram_din[15:8];
            if (!ram_dsn[0]) md[1][7:0]  = ram_din[7:0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("main_ok", main_ok, e_main);
      check("ram_ok", ram_ok, e_ram);
      check("snd_ok", snd_ok, e_snd);
      if (e_main) check("main_data", main_data, e_main_d);
      if (e_ram && ram_rnw) check("ram_data", ram_data, e_ram_d);
      if (e_snd) check("snd_data", snd_data, e_snd_d);
      check("rd_wr_excl", ba_rd & ba_wr, 0);
    end
  end

  function automatic logic ok_of(input int w);
    case (w)
      0: return main_ok;
      1: return ram_ok;
      default: return snd_ok;
    endcase
  endfunction

  task automatic wait_ok(input int w, input string name);
    int n = 0;
    while (!ok_of(w) && n < 60) begin @(negedge clk); n++; end
    check(name, ok_of(w), 1);
  endtask

  task automatic wait_set(input logic [2:0] m, input string name);
    int n = 0;
    while ((m & {snd_ok, ram_ok, main_ok}) != m && n < 200) begin @(negedge clk); n++; end
    check(name, m & {snd_ok, ram_ok, main_ok}, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    main_cs = 0; ram_cs = 0; snd_cs = 0; ram_rnw = 1;
    main_addr = '0; ram_addr = '0; snd_addr = '0; ram_dsn = 2'b11; ram_din = '0;
    mem[22'h00_1234] = 16'hBEEF;
    mem[22'h30_0010] = 16'h1122;
    mem[22'h20_0080] = 16'h5A3C;
    repeat (3) @(negedge clk);
    check("rst_main_ok", main_ok, 0);
    check("rst_ram_ok", ram_ok, 0);
    check("rst_snd_ok", snd_ok, 0);
    check("rst_data", {main_data, ram_data}, 0);
    check("rst_snd_data", snd_data, 0);
    check("rst_ba_addr", ba_addr, 0);
    check("rst_req", {ba_rd, ba_wr, ba_din_m}, 0);
    check("rst_ba_din", ba_din, 0);
    rst_n = 1;

    // main miss, then hit
    ack_dly = 0; rdy_dly = 2;
    main_addr = 18'h01234; main_cs = 1;
    @(negedge clk);
    check("t1_rd_rise", ba_rd, 1);
    check("t1_ba_addr", ba_addr, 22'h00_1234);
    wait_ok(0, "t1_miss_ok");
    check("t1_data", main_data, 16'hBEEF);
    rc = req_cnt;
    main_cs = 0;
    @(negedge clk);
    main_cs = 1;
    @(negedge clk);
    check("t1_hit_ok", main_ok, 1);
    check("t1_hit_data", main_data, 16'hBEEF);
    check("t1_hit_no_rd", ba_rd, 0);
    check("t1_hit_no_req", req_cnt - rc, 0);
    main_cs = 0;

    // round robin from reset, then after a ram grant
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    glog.delete();
    ack_dly = 1; rdy_dly = 1;
    main_addr = 18'h00100; ram_addr = 18'h00200; ram_rnw = 1; snd_addr = 19'h00600;
    main_cs = 1; ram_cs = 1; snd_cs = 1;
    wait_set(3'b111, "t2_all_ok");
    check("t2_n", glog.size(), 3);
    check("t2_g0", glog[0], 22'h00_0100);
    check("t2_g1", glog[1], 22'h30_0200);
    check("t2_g2", glog[2], 22'h20_0300);
    main_cs = 0; ram_cs = 0; snd_cs = 0;
    @(negedge clk);
    glog.delete();
    ram_addr = 18'h00210; ram_cs = 1;
    wait_ok(1, "t2_ram_ok");
    ram_cs = 0;
    @(negedge clk);
    main_addr = 18'h00110; snd_addr = 19'h00620; main_cs = 1; snd_cs = 1;
    wait_set(3'b101, "t2b_ok");
    check("t2b_n", glog.size(), 3);
    check("t2b_g0", glog[0], 22'h30_0210);
    check("t2b_g1", glog[1], 22'h20_0310);
    check("t2b_g2", glog[2], 22'h00_0110);
    main_cs = 0; snd_cs = 0;
    @(negedge clk);

    // RAM write with cache merge
    ram_addr = 18'h00010; ram_rnw = 1; ram_cs = 1;
    wait_ok(1, "t3_rd_ok");
    check("t3_rd_data", ram_data, 16'h1122);
    ram_cs = 0;
    @(negedge clk);
    rc = req_cnt;
    ram_rnw = 0; ram_din = 16'hAABB; ram_dsn = 2'b01; ram_cs = 1;
    @(negedge clk);
    check("t3_wr_rise", {ba_wr, ba_rd}, 2'b10);
    check("t3_mask", ba_din_m, 2'b01);
    check("t3_din", ba_din, 16'hAABB);
    wait_ok(1, "t3_wr_ok");
    repeat (4) @(negedge clk);
    check("t3_ok_held", ram_ok, 1);
    check("t3_one_wr", req_cnt - rc, 1);
    ram_cs = 0; ram_rnw = 1;
    @(negedge clk);
    rc = req_cnt;
    ram_cs = 1;
    @(negedge clk);
    check("t3_hit_ok", ram_ok, 1);
    check("t3_merged", ram_data, 16'hAA22);
    check("t3_no_req", req_cnt - rc, 0);
    ram_cs = 0;
    @(negedge clk);

    // sound byte select
    snd_addr = 19'h00101; snd_cs = 1;
    wait_ok(2, "t4_ok");
    check("t4_hi", snd_data, 8'h5A);
    rc = req_cnt;
    snd_addr = 19'h00100;
    @(negedge clk);
    check("t4_lo_ok", snd_ok, 1);
    check("t4_lo", snd_data, 8'h3C);
    check("t4_no_req", req_cnt - rc, 0);
    snd_cs = 0;
    @(negedge clk);

    // cs dropped during WAIT
    ack_dly = 0; rdy_dly = 4;
    rc = req_cnt;
    main_addr = 18'h02000; main_cs = 1;
    @(negedge clk);
    @(negedge clk);
    main_cs = 0;
    repeat (8) @(negedge clk);
    check("t5_ok_low", main_ok, 0);
    check("t5_one_req", req_cnt - rc, 1);
    check("t5_done", phase, 0);
    main_cs = 1;
    @(negedge clk);
    check("t5_hit", main_ok, 1);
    check("t5_data", main_data, 16'hE3A5);
    main_cs = 0;
    @(negedge clk);

    // reset during REQ
    ack_dly = 5; rdy_dly = 1;
    main_addr = 18'h03000; main_cs = 1;
    @(negedge clk);
    check("t6_req", ba_rd, 1);
    #2 rst_n = 0;
    #1;
    check("t6_rd_drop", {ba_rd, ba_wr}, 0);
    check("t6_oks", {main_ok, ram_ok, snd_ok}, 0);
    main_cs = 0;
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    main_addr = 18'h02000; main_cs = 1;
    @(negedge clk);
    check("t6_miss_ok", main_ok, 0);
    check("t6_miss_rd", ba_rd, 1);
    wait_ok(0, "t6_refetch");
    check("t6_data", main_data, 16'hE3A5);
    main_cs = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
